// File: rtl/hdlc_pkg.sv
// Shared constants, reader state encoding and the byte-wise CRC-16/X.25 step
// for the HDLC receive-side frame reader.
package hdlc_pkg;

   localparam int          ADDR_W      = 9;
   localparam logic [8:0]  LEN_LO_ADDR = 9'd510;
   localparam logic [8:0]  LEN_HI_ADDR = 9'd511;
   localparam logic [8:0]  MAX_LEN     = 9'd510;
   localparam logic [8:0]  MIN_LEN     = 9'd3;

   localparam logic [15:0] CRC_INIT    = 16'hFFFF;
   localparam logic [15:0] CRC_POLY_R  = 16'h8408;
   localparam logic [15:0] CRC_GOOD    = 16'hF0B8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_LO  = 3'd1,
      ST_RD_HI  = 3'd2,
      ST_LENCHK = 3'd3,
      ST_FETCH  = 3'd4,
      ST_EMIT   = 3'd5,
      ST_CHECK  = 3'd6,
      ST_DONE   = 3'd7
   } rd_state_e;

   // Reflected CRC-16 step over one byte, LSB first (same bit order as the line).
   function automatic logic [15:0] crc16_byte_upd(input logic [15:0] crc,
                                                  input logic [7:0]  data);
      logic [15:0] c;
      c = crc ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         if (c[0]) begin
            c = {1'b0, c[15:1]} ^ CRC_POLY_R;
         end else begin
            c = {1'b0, c[15:1]};
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/hdlc_crc16_byte.sv
// Combinational one-byte CRC-16/X.25 update (reflected, no final XOR).
module hdlc_crc16_byte
   import hdlc_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  byte_in,
   output logic [15:0] crc_out
);

   // Advance the running CRC by one byte.
   always_comb begin
      crc_out = crc16_byte_upd(crc_in, byte_in);
   end

endmodule

// File: rtl/hdlc_rx_frame_reader.sv
// Captures the HDLC receiver's byte writes into a local 512x8 buffer, and on
// each end-of-frame interrupt reads the length word, replays the frame through
// the CRC and streams the payload (FCS stripped) on a valid/ready interface.
module hdlc_rx_frame_reader
   import hdlc_pkg::*;
(
   input  logic        clkr,
   input  logic        rst_n,
   input  logic [7:0]  ramd,
   input  logic [8:0]  rama,
   input  logic        hwr,
   input  logic        interrupt,
   output logic [7:0]  m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_last,
   output logic        frame_done,
   output logic [8:0]  frame_len,
   output logic        crc_ok,
   output logic        err_len,
   output logic        overrun,
   output logic        busy
);

   logic [7:0]  mem [0:511];

   rd_state_e   state_q, state_d;
   logic        int_dly_q;
   logic [7:0]  rd_data_q;
   logic [7:0]  len_lo_q, len_lo_d;
   logic [8:0]  frame_len_q, frame_len_d;
   logic [8:0]  rd_addr_q, rd_addr_d;
   logic [15:0] crc_q, crc_d;
   logic        m_valid_q, m_valid_d;
   logic        m_last_q, m_last_d;
   logic        frame_done_q, frame_done_d;
   logic        crc_ok_q, crc_ok_d;
   logic        err_len_q, err_len_d;
   logic        overrun_q, overrun_d;
   logic        busy_q, busy_d;

   logic        start;
   logic        rd_en;
   logic [8:0]  ram_raddr;
   logic [8:0]  len_w;
   logic [8:0]  pay_len;
   logic [8:0]  last_addr;
   logic [8:0]  rd_addr_inc;
   logic [15:0] crc_next;

   // CRC of the byte currently held in the read register.
   hdlc_crc16_byte u_crc (
      .crc_in  (crc_q),
      .byte_in (rd_data_q),
      .crc_out (crc_next)
   );

   // Buffer write port: the receiver may write in any state.
   always_ff @(posedge clkr) begin
      if (hwr) begin
         mem[rama] <= ramd;
      end
   end

   // Buffer read port; the read register only loads on an explicit read so a
   // stalled payload byte stays put even if the receiver keeps writing.
   always_ff @(posedge clkr or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= 8'h00;
      end else if (rd_en) begin
         rd_data_q <= mem[ram_raddr];
      end else begin
         rd_data_q <= rd_data_q;
      end
   end

   assign start       = interrupt & ~int_dly_q;
   assign pay_len     = frame_len_q - 9'd2;
   assign last_addr   = frame_len_q - 9'd3;
   assign rd_addr_inc = rd_addr_q + 9'd1;

   // Reader FSM: next state, datapath updates and registered outputs.
   always_comb begin
      state_d      = state_q;
      len_lo_d     = len_lo_q;
      frame_len_d  = frame_len_q;
      rd_addr_d    = rd_addr_q;
      crc_d        = crc_q;
      m_valid_d    = m_valid_q;
      m_last_d     = m_last_q;
      crc_ok_d     = crc_ok_q;
      err_len_d    = err_len_q;
      rd_en        = 1'b0;
      ram_raddr    = rd_addr_q;
      len_w        = {rd_data_q[0], len_lo_q};

      if ((state_q != ST_IDLE) && (start || hwr)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_RD_LO;
               crc_ok_d  = 1'b0;
               err_len_d = 1'b0;
               overrun_d = 1'b0;
               crc_d     = CRC_INIT;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_RD_LO: begin
            rd_en     = 1'b1;
            ram_raddr = LEN_LO_ADDR;
            state_d   = ST_RD_HI;
         end
         ST_RD_HI: begin
            len_lo_d  = rd_data_q;
            rd_en     = 1'b1;
            ram_raddr = LEN_HI_ADDR;
            state_d   = ST_LENCHK;
         end
         ST_LENCHK: begin
            frame_len_d = len_w;
            if ((len_w < MIN_LEN) || (len_w > MAX_LEN)) begin
               err_len_d = 1'b1;
               crc_ok_d  = 1'b0;
               state_d   = ST_DONE;
            end else begin
               rd_addr_d = 9'd0;
               state_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            rd_en     = 1'b1;
            ram_raddr = rd_addr_q;
            state_d   = ST_EMIT;
            // Decide now whether the byte arriving next cycle is payload.
            if (rd_addr_q < pay_len) begin
               m_valid_d = 1'b1;
               m_last_d  = (rd_addr_q == last_addr);
            end else begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
            end
         end
         ST_EMIT: begin
            if (m_valid_q && !m_ready) begin
               state_d = ST_EMIT;
            end else begin
               // Payload transfer or FCS byte: fold into CRC exactly once.
               crc_d     = crc_next;
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               rd_addr_d = rd_addr_inc;
               if (rd_addr_inc == frame_len_q) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         ST_CHECK: begin
            crc_ok_d = (crc_q == CRC_GOOD);
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
         end
      endcase

      frame_done_d = (state_d == ST_DONE);
      busy_d       = (state_d != ST_IDLE);
   end

   // State and output registers; reset aborts any frame in progress.
   always_ff @(posedge clkr or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         int_dly_q    <= 1'b0;
         len_lo_q     <= 8'h00;
         frame_len_q  <= 9'd0;
         rd_addr_q    <= 9'd0;
         crc_q        <= CRC_INIT;
         m_valid_q    <= 1'b0;
         m_last_q     <= 1'b0;
         frame_done_q <= 1'b0;
         crc_ok_q     <= 1'b0;
         err_len_q    <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         int_dly_q    <= interrupt;
         len_lo_q     <= len_lo_d;
         frame_len_q  <= frame_len_d;
         rd_addr_q    <= rd_addr_d;
         crc_q        <= crc_d;
         m_valid_q    <= m_valid_d;
         m_last_q     <= m_last_d;
         frame_done_q <= frame_done_d;
         crc_ok_q     <= crc_ok_d;
         err_len_q    <= err_len_d;
         overrun_q    <= overrun_d;
         busy_q       <= busy_d;
      end
   end

   assign m_data     = rd_data_q;
   assign m_valid    = m_valid_q;
   assign m_last     = m_last_q;
   assign frame_done = frame_done_q;
   assign frame_len  = frame_len_q;
   assign crc_ok     = crc_ok_q;
   assign err_len    = err_len_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_hdlc_rx_frame_reader.sv
// Directed bench for hdlc_rx_frame_reader: loads frames through the receiver
// write port, triggers reads and checks the payload stream and status.
module tb_hdlc_rx_frame_reader;

   logic       clkr = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ramd = 8'h00;
   logic [8:0] rama = 9'd0;
   logic       hwr = 1'b0;
   logic       interrupt = 1'b0;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_last;
   logic       frame_done;
   logic [8:0] frame_len;
   logic       crc_ok;
   logic       err_len;
   logic       overrun;
   logic       busy;

   int cmp_cnt = 0;
   int mis_cnt = 0;

   // captured results of one frame read
   logic [7:0] got [$];
   int         last_cnt, last_pos, hold_bad, valid_cnt, done_seen;
   logic [8:0] st_len;
   logic       st_crc, st_err, st_ovr;

   hdlc_rx_frame_reader dut (
      .clkr       (clkr),
      .rst_n      (rst_n),
      .ramd       (ramd),
      .rama       (rama),
      .hwr        (hwr),
      .interrupt  (interrupt),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .frame_done (frame_done),
      .frame_len  (frame_len),
      .crc_ok     (crc_ok),
      .err_len    (err_len),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clkr = ~clkr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         mis_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [8:0] a, input logic [7:0] d);
      @(negedge clkr);
      hwr  = 1'b1;
      rama = a;
      ramd = d;
   endtask

   // "123456789" + FCS 0x6E,0x90; optionally corrupt byte 4.
   task automatic load_frame(input bit bad, input logic [8:0] len);
      for (int i = 0; i < 9; i++) begin
         wr(9'(i), (bad && i == 4) ? 8'h00 : 8'(8'h31 + i));
      end
      wr(9'd9, 8'h6E);
      wr(9'd10, 8'h90);
      wr(9'd510, len[7:0]);
      wr(9'd511, {7'd0, len[8]});
      @(negedge clkr);
      hwr = 1'b0;
   endtask

   task automatic load_len(input logic [8:0] len);
      wr(9'd510, len[7:0]);
      wr(9'd511, {7'd0, len[8]});
      @(negedge clkr);
      hwr = 1'b0;
   endtask

   // Pulse interrupt, then act as the sink until frame_done (or a reset point).
   task automatic run_frame(input string tag, input int stall_at, input int inject_at, input int reset_at);
      int   stall_left;
      bit   stalled, injected, inj_clear, timed_out;
      logic pv, pr, pl;
      logic [7:0] pd;
      got.delete();
      last_cnt = 0; last_pos = -1; hold_bad = 0; valid_cnt = 0; done_seen = 0;
      stall_left = 0; stalled = 0; injected = 0; inj_clear = 0; timed_out = 1;
      pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = 8'h00;
      @(negedge clkr);
      interrupt = 1'b1;
      m_ready   = 1'b1;
      @(negedge clkr);
      interrupt = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clkr);
         if (inj_clear) begin
            interrupt = 1'b0;
            hwr       = 1'b0;
            inj_clear = 0;
         end
         if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) hold_bad++;
         if (reset_at >= 0 && got.size() == reset_at && m_valid === 1'b1) begin
            rst_n = 1'b0;
            timed_out = 0;
            break;
         end
         if (stall_at >= 0 && !stalled && got.size() == stall_at) begin
            stalled = 1;
            stall_left = 5;
         end
         if (stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
         end else begin
            m_ready = 1'b1;
         end
         if (inject_at >= 0 && !injected && got.size() == inject_at) begin
            injected  = 1;
            inj_clear = 1;
            interrupt = 1'b1;
            hwr       = 1'b1;
            rama      = 9'd200;
            ramd      = 8'hA5;
         end
         if (m_valid === 1'b1) valid_cnt++;
         if (m_valid === 1'b1 && m_ready) begin
            got.push_back(m_data);
            if (m_last === 1'b1) begin
               last_cnt++;
               last_pos = got.size() - 1;
            end
         end
         pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
         if (frame_done === 1'b1) begin
            done_seen = 1;
            st_len = frame_len; st_crc = crc_ok; st_err = err_len; st_ovr = overrun;
            timed_out = 0;
            break;
         end
      end
      if (timed_out) check({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic expect_stream(input string tag, input bit bad);
      int n;
      check({tag, "_count"}, got.size(), 32'd9);
      n = (got.size() < 9) ? got.size() : 9;
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]},
               {24'd0, (bad && i == 4) ? 8'h00 : 8'(8'h31 + i)});
      end
      check({tag, "_last_cnt"}, last_cnt, 32'd1);
      check({tag, "_last_pos"}, last_pos, 32'd8);
      check({tag, "_hold"}, hold_bad, 32'd0);
   endtask

   task automatic expect_done_pulse(input string tag);
      @(negedge clkr);
      check({tag, "_done_pulse"}, {31'd0, frame_done}, 32'd0);
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      // reset state
      #1;
      check("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("rst_m_data", {24'd0, m_data}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_frame_len", {23'd0, frame_len}, 32'd0);
      check("rst_crc_ok", {31'd0, crc_ok}, 32'd0);
      check("rst_flags", {29'd0, err_len, overrun, busy}, 32'd0);
      repeat (3) @(negedge clkr);
      rst_n = 1'b1;

      // 1: good frame
      load_frame(1'b0, 9'd11);
      run_frame("t1", -1, -1, -1);
      expect_stream("t1", 1'b0);
      check("t1_done", done_seen, 32'd1);
      check("t1_len", {23'd0, st_len}, 32'd11);
      check("t1_crc_ok", {31'd0, st_crc}, 32'd1);
      check("t1_err_len", {31'd0, st_err}, 32'd0);
      check("t1_overrun", {31'd0, st_ovr}, 32'd0);
      expect_done_pulse("t1");

      // 2: corrupted byte 4
      load_frame(1'b1, 9'd11);
      run_frame("t2", -1, -1, -1);
      expect_stream("t2", 1'b1);
      check("t2_crc_ok", {31'd0, st_crc}, 32'd0);
      check("t2_err_len", {31'd0, st_err}, 32'd0);
      expect_done_pulse("t2");

      // 3: back-pressure while 0x33 is presented
      load_frame(1'b0, 9'd11);
      run_frame("t3", 2, -1, -1);
      expect_stream("t3", 1'b0);
      check("t3_crc_ok", {31'd0, st_crc}, 32'd1);

      // 4: illegal lengths
      load_len(9'd2);
      run_frame("t4a", -1, -1, -1);
      check("t4a_no_valid", valid_cnt, 32'd0);
      check("t4a_done", done_seen, 32'd1);
      check("t4a_err_len", {31'd0, st_err}, 32'd1);
      check("t4a_crc_ok", {31'd0, st_crc}, 32'd0);
      check("t4a_len", {23'd0, st_len}, 32'd2);
      load_len(9'd511);
      run_frame("t4b", -1, -1, -1);
      check("t4b_no_valid", valid_cnt, 32'd0);
      check("t4b_err_len", {31'd0, st_err}, 32'd1);
      check("t4b_len", {23'd0, st_len}, 32'd511);

      // 5: second interrupt edge and a write while streaming
      load_frame(1'b0, 9'd11);
      run_frame("t5", -1, 4, -1);
      expect_stream("t5", 1'b0);
      check("t5_crc_ok", {31'd0, st_crc}, 32'd1);
      check("t5_err_len", {31'd0, st_err}, 32'd0);
      check("t5_overrun", {31'd0, st_ovr}, 32'd1);
      repeat (10) @(negedge clkr);
      check("t5_no_restart", {31'd0, busy}, 32'd0);
      check("t5_overrun_held", {31'd0, overrun}, 32'd1);

      // 6: reset while a payload byte is presented
      load_frame(1'b0, 9'd11);
      run_frame("t6", -1, -1, 4);
      #1;
      check("t6_rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_len", {23'd0, frame_len}, 32'd0);
      check("t6_rst_last", {31'd0, m_last}, 32'd0);
      repeat (3) @(negedge clkr);
      check("t6_no_done", {31'd0, frame_done}, 32'd0);
      rst_n = 1'b1;
      load_frame(1'b0, 9'd11);
      run_frame("t6b", -1, -1, -1);
      expect_stream("t6b", 1'b0);
      check("t6b_crc_ok", {31'd0, st_crc}, 32'd1);
      check("t6b_len", {23'd0, st_len}, 32'd11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
      $finish;
   end

endmodule
